// File: rtl/pc_seq_pkg.sv
// Shared definitions for the picoNISC control path.
// Holds the sequencing-op encoding so the control-word decoder and the
// program-counter sequencer agree on the meaning of every seqOp value.
package pc_seq_pkg;

    localparam int unsigned SEQ_OP_W = 3;

    // Sequencing field of the control word.
    typedef enum logic [SEQ_OP_W-1:0] {
        SEQ_NEXT = 3'd0,  // addr+1
        SEQ_JMP  = 3'd1,  // unconditional branch
        SEQ_JZ   = 3'd2,  // branch if zero flag set
        SEQ_JNZ  = 3'd3,  // branch if zero flag clear
        SEQ_CALL = 3'd4,  // push return address, branch
        SEQ_RET  = 3'd5,  // pop return address
        SEQ_LDC  = 3'd6,  // load loop counter from target
        SEQ_DJNZ = 3'd7   // decrement counter, branch while not finishing
    } seq_op_t;

endpackage : pc_seq_pkg

// File: rtl/pc_seq_ret_stack.sv
// ret_stack: Psize x Depth LIFO holding subroutine return addresses.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   push, push_data write push_data on top (ignored when full)
//   pop             discard the top entry (ignored when empty)
//   top_data        current top entry (valid only when !empty)
//   full, empty     pointer == Depth / pointer == 0
module ret_stack #(
    parameter int unsigned Psize = 4,
    parameter int unsigned Depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Psize-1:0] push_data,
    input  logic             pop,
    output logic [Psize-1:0] top_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(Depth + 1);
    localparam int unsigned IDX_W = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [Psize-1:0] mem_q [Depth];
    logic [Psize-1:0] mem_d [Depth];

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    // Pointer counts occupied entries; write slot is ptr, top is ptr-1.
    always_comb begin
        full    = (ptr_q == PTR_W'(Depth));
        empty   = (ptr_q == '0);
        wr_idx  = IDX_W'(ptr_q);
        top_idx = IDX_W'(ptr_q - PTR_W'(1));
        top_data = mem_q[top_idx];
    end

    // Next-state: push and pop are mutually exclusive from the sequencer;
    // boundary guards keep the pointer in 0..Depth regardless.
    always_comb begin
        ptr_d = ptr_q;
        mem_d = mem_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_data;
            ptr_d         = ptr_q + PTR_W'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            mem_q <= mem_d;
        end
    end

endmodule : ret_stack

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer for the picoNISC control path.
// Drives the program-memory address and consumes the sequencing fields of
// the control word returned combinationally for that address, executing one
// control word per clock.
// Ports:
//   clk      system clock, rising-edge state updates
//   nReset   asynchronous active-low reset
//   stall    freezes all state when high
//   seqOp    sequencing op of the current control word (seq_op_t)
//   target   branch/call target or loop-count load value
//   zero     datapath zero flag for JZ/JNZ
//   addr     registered program address
//   loopCnt  loop counter (debug visibility)
//   fault    sticky return-stack overflow/underflow flag
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned Psize = 4,
    parameter int unsigned Depth = 2
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic                stall,
    input  logic [SEQ_OP_W-1:0] seqOp,
    input  logic [Psize-1:0]    target,
    input  logic                zero,
    output logic [Psize-1:0]    addr,
    output logic [Psize-1:0]    loopCnt,
    output logic                fault
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [Psize-1:0] addr_q, addr_d;
    logic [Psize-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;

    logic             stk_push;
    logic             stk_pop;
    logic [Psize-1:0] stk_top;
    logic             stk_full;
    logic             stk_empty;

    logic [Psize-1:0] addr_inc;
    seq_op_t          op;

    assign addr_inc = addr_q + Psize'(1);
    assign op       = seq_op_t'(seqOp);

    // Return-address LIFO.
    ret_stack #(
        .Psize (Psize),
        .Depth (Depth)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (nReset),
        .push      (stk_push),
        .push_data (addr_inc),
        .pop       (stk_pop),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Next-state, next-address mux and stack control.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        if (state_q == ST_RUN && !stall) begin
            unique case (op)
                SEQ_NEXT: addr_d = addr_inc;
                SEQ_JMP:  addr_d = target;
                SEQ_JZ:   addr_d = zero ? target : addr_inc;
                SEQ_JNZ:  addr_d = zero ? addr_inc : target;
                SEQ_CALL: begin
                    // Overflow: addr stays on the faulting CALL.
                    if (stk_full) begin
                        state_d = ST_FAULT;
                    end else begin
                        stk_push = 1'b1;
                        addr_d   = target;
                    end
                end
                SEQ_RET: begin
                    // Underflow: addr stays on the faulting RET.
                    if (stk_empty) begin
                        state_d = ST_FAULT;
                    end else begin
                        stk_pop = 1'b1;
                        addr_d  = stk_top;
                    end
                end
                SEQ_LDC: begin
                    cnt_d  = target;
                    addr_d = addr_inc;
                end
                SEQ_DJNZ: begin
                    // Falls through only when this pass takes the count to 0;
                    // a count of 0 wraps to all-ones and keeps looping.
                    cnt_d  = cnt_q - Psize'(1);
                    addr_d = (cnt_q != Psize'(1)) ? target : addr_inc;
                end
                default: addr_d = addr_inc;
            endcase
        end

        fault_d = (state_d == ST_FAULT);
    end

    // State registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign addr    = addr_q;
    assign loopCnt = cnt_q;
    assign fault   = fault_q;

endmodule : pc_seq

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios followed by random
// sequencing ops, all compared against a behavioural sequencer model.
module tb_pc_seq;
    import pc_seq_pkg::*;

    localparam int PSIZE = 4;
    localparam int DEPTH = 2;
    localparam int MASK  = (1 << PSIZE) - 1;

    logic             clk;
    logic             nReset;
    logic             stall;
    logic [2:0]       seqOp;
    logic [PSIZE-1:0] target;
    logic             zero;
    logic [PSIZE-1:0] addr;
    logic [PSIZE-1:0] loopCnt;
    logic             fault;

    int tests;
    int fails;

    // Behavioural model state.
    int m_addr;
    int m_cnt;
    bit m_fault;
    int m_stack[$];

    pc_seq #(.Psize(PSIZE), .Depth(DEPTH)) dut (
        .clk     (clk),
        .nReset  (nReset),
        .stall   (stall),
        .seqOp   (seqOp),
        .target  (target),
        .zero    (zero),
        .addr    (addr),
        .loopCnt (loopCnt),
        .fault   (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_addr  = 0;
        m_cnt   = 0;
        m_fault = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_step(input seq_op_t op, input int tgt, input bit z, input bit st);
        int nxt;
        nxt = (m_addr + 1) & MASK;
        if (m_fault || st) return;
        case (op)
            SEQ_NEXT: m_addr = nxt;
            SEQ_JMP:  m_addr = tgt;
            SEQ_JZ:   m_addr = z ? tgt : nxt;
            SEQ_JNZ:  m_addr = z ? nxt : tgt;
            SEQ_CALL: begin
                if (m_stack.size() >= DEPTH) m_fault = 1'b1;
                else begin
                    m_stack.push_back(nxt);
                    m_addr = tgt;
                end
            end
            SEQ_RET: begin
                if (m_stack.size() == 0) m_fault = 1'b1;
                else m_addr = m_stack.pop_back();
            end
            SEQ_LDC: begin
                m_cnt  = tgt;
                m_addr = nxt;
            end
            SEQ_DJNZ: begin
                m_addr = (m_cnt != 1) ? tgt : nxt;
                m_cnt  = (m_cnt - 1) & MASK;
            end
            default: m_addr = nxt;
        endcase
    endtask

    task automatic check_model(input string tag);
        tests++;
        assert (addr === PSIZE'(m_addr)) else begin
            fails++;
            $error("FAIL %s addr: got %0d expected %0d", tag, addr, m_addr);
        end
        tests++;
        assert (loopCnt === PSIZE'(m_cnt)) else begin
            fails++;
            $error("FAIL %s loopCnt: got %0d expected %0d", tag, loopCnt, m_cnt);
        end
        tests++;
        assert (fault === m_fault) else begin
            fails++;
            $error("FAIL %s fault: got %0b expected %0b", tag, fault, m_fault);
        end
    endtask

    task automatic expect_lit(input string tag, input int a, input int c, input bit f);
        tests++;
        assert (addr === PSIZE'(a) && loopCnt === PSIZE'(c) && fault === f) else begin
            fails++;
            $error("FAIL %s literal: got addr=%0d cnt=%0d fault=%0b expected addr=%0d cnt=%0d fault=%0b",
                   tag, addr, loopCnt, fault, a, c, f);
        end
    endtask

    // Drive one control word, advance one edge, compare with the model.
    task automatic step(input seq_op_t op, input int tgt, input bit z, input bit st, input string tag);
        seqOp  = op;
        target = PSIZE'(tgt);
        zero   = z;
        stall  = st;
        model_step(op, tgt, z, st);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // Reset asserted between edges: must act without a clock edge.
    task automatic do_reset(input string tag);
        nReset = 1'b0;
        #1;
        model_reset();
        check_model({tag, "_async"});
        @(posedge clk);
        #1;
        check_model({tag, "_held"});
        #3;
        nReset = 1'b1;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        nReset = 1'b0;
        stall  = 1'b0;
        seqOp  = 3'd0;
        target = '0;
        zero   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_model("por");
        expect_lit("por", 0, 0, 1'b0);
        #3;
        nReset = 1'b1;

        // Sequential fetch with wrap.
        for (int i = 0; i < 20; i++) step(SEQ_NEXT, 0, 1'b0, 1'b0, "next");
        expect_lit("next_wrap", 4, 0, 1'b0);

        // Conditional branches from addr 3.
        do_reset("rst1");
        for (int i = 0; i < 3; i++) step(SEQ_NEXT, 0, 1'b0, 1'b0, "to3");
        step(SEQ_JZ, 9, 1'b1, 1'b0, "jz_taken");
        expect_lit("jz_taken", 9, 0, 1'b0);
        step(SEQ_JMP, 3, 1'b0, 1'b0, "jmp3");
        step(SEQ_JZ, 9, 1'b0, 1'b0, "jz_fall");
        expect_lit("jz_fall", 4, 0, 1'b0);
        step(SEQ_JMP, 3, 1'b0, 1'b0, "jmp3");
        step(SEQ_JNZ, 9, 1'b0, 1'b0, "jnz_taken");
        expect_lit("jnz_taken", 9, 0, 1'b0);
        step(SEQ_JMP, 3, 1'b0, 1'b0, "jmp3");
        step(SEQ_JNZ, 9, 1'b1, 1'b0, "jnz_fall");
        expect_lit("jnz_fall", 4, 0, 1'b0);

        // Call/return, nesting, then overflow.
        step(SEQ_JMP, 5, 1'b0, 1'b0, "jmp5");
        step(SEQ_CALL, 12, 1'b0, 1'b0, "call12");
        expect_lit("call12", 12, 0, 1'b0);
        step(SEQ_RET, 0, 1'b0, 1'b0, "ret6");
        expect_lit("ret6", 6, 0, 1'b0);
        step(SEQ_CALL, 10, 1'b0, 1'b0, "call_a");
        step(SEQ_CALL, 14, 1'b0, 1'b0, "call_b");
        step(SEQ_RET, 0, 1'b0, 1'b0, "ret_b");
        expect_lit("ret_b", 11, 0, 1'b0);
        step(SEQ_RET, 0, 1'b0, 1'b0, "ret_a");
        expect_lit("ret_a", 7, 0, 1'b0);
        step(SEQ_CALL, 10, 1'b0, 1'b0, "call_c");
        step(SEQ_CALL, 14, 1'b0, 1'b0, "call_d");
        step(SEQ_CALL, 2, 1'b0, 1'b0, "call_ovf");
        expect_lit("call_ovf", 14, 0, 1'b1);
        step(SEQ_RET, 0, 1'b0, 1'b0, "fault_ret");
        step(SEQ_JMP, 3, 1'b0, 1'b0, "fault_jmp");
        step(SEQ_LDC, 5, 1'b0, 1'b0, "fault_ldc");
        expect_lit("fault_frozen", 14, 0, 1'b1);
        do_reset("rst2");
        step(SEQ_NEXT, 0, 1'b0, 1'b0, "post_rst");
        expect_lit("post_rst", 1, 0, 1'b0);

        // Counted loop.
        step(SEQ_LDC, 3, 1'b0, 1'b0, "ldc3");
        expect_lit("ldc3", 2, 3, 1'b0);
        step(SEQ_DJNZ, 2, 1'b0, 1'b0, "djnz1");
        expect_lit("djnz1", 2, 2, 1'b0);
        step(SEQ_DJNZ, 2, 1'b0, 1'b0, "djnz2");
        expect_lit("djnz2", 2, 1, 1'b0);
        step(SEQ_DJNZ, 2, 1'b0, 1'b0, "djnz3");
        expect_lit("djnz3", 3, 0, 1'b0);
        step(SEQ_DJNZ, 8, 1'b0, 1'b0, "djnz_wrap");
        expect_lit("djnz_wrap", 8, 15, 1'b0);

        // Stall masks an underflowing RET.
        do_reset("rst3");
        step(SEQ_NEXT, 0, 1'b0, 1'b0, "pre_stall");
        for (int i = 0; i < 4; i++) step(SEQ_RET, 0, 1'b0, 1'b1, "stall_ret");
        expect_lit("stall_ret", 1, 0, 1'b0);
        step(SEQ_RET, 0, 1'b0, 1'b0, "ret_unf");
        expect_lit("ret_unf", 1, 0, 1'b1);

        // Random ops against the model; reset periodically out of FAULT.
        do_reset("rst4");
        for (int i = 0; i < 600; i++) begin
            if (m_fault && $urandom_range(0, 3) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step(seq_op_t'(3'($urandom_range(0, 7))),
                     int'($urandom_range(0, MASK)),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 4) == 0),
                     "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pc_seq
